// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv tile scheduler and related address generators.
package conv_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        FIN
    } sched_state_t;

    function automatic int unsigned out_dim(input int unsigned img, input int unsigned ker);
        return img - ker + 1;
    endfunction

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/window_raster_counter.sv
// Raster (row, col) window pointer over an OUT x OUT grid with advance-by-n and a last flag.
module window_raster_counter #(
    parameter int unsigned OUT      = 4,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned MAX_STEP = 4,
    parameter int unsigned CNT_W    = $clog2(OUT * OUT + 1),
    parameter int unsigned STEP_W   = $clog2(MAX_STEP + 1)
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              clear,
    input  logic              advance,
    input  logic [STEP_W-1:0] step_n,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic [CNT_W-1:0]  count,
    output logic              last
);

    localparam logic [CNT_W-1:0]  TotalC   = CNT_W'(OUT * OUT);
    localparam logic [ADDR_W-1:0] OutLastC = ADDR_W'(OUT - 1);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        count_d = count_q;
        if (clear) begin
            row_d   = '0;
            col_d   = '0;
            count_d = '0;
        end else if (advance) begin
            for (int unsigned i = 0; i < MAX_STEP; i++) begin
                if (STEP_W'(i) < step_n && count_d < TotalC) begin
                    count_d = count_d + CNT_W'(1);
                    // The pointer parks on the final window instead of wrapping past OUT-1.
                    if (count_d < TotalC) begin
                        if (col_d == OutLastC) begin
                            col_d = '0;
                            row_d = row_d + ADDR_W'(1);
                        end else begin
                            col_d = col_d + ADDR_W'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            row_q   <= '0;
            col_q   <= '0;
            count_q <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            count_q <= count_d;
        end
    end

    assign row   = row_q;
    assign col   = col_q;
    assign count = count_q;
    assign last  = (count_q == TotalC);

endmodule

// File: rtl/conv_tile_scheduler.sv
// Issues 3x3 window origins to NCORE conv cores in raster batches, captures results,
// applies ReLU and streams them out over a valid/ready write port.
module conv_tile_scheduler
    import conv_pkg::*;
#(
    parameter int unsigned IMG_SIZE  = 320,
    parameter int unsigned KER_SIZE  = 3,
    parameter int unsigned WIDTH_BIT = DATA_W,
    parameter int unsigned NCORE     = 4,
    parameter int unsigned CORE_LAT  = 1,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                             clock,
    input  logic                             nreset,
    input  logic                             start,
    output logic [NCORE-1:0]                 issue_valid,
    output logic [NCORE-1:0][ADDR_W-1:0]     issue_row,
    output logic [NCORE-1:0][ADDR_W-1:0]     issue_col,
    input  logic [NCORE-1:0][WIDTH_BIT-1:0]  core_result,
    output logic                             wr_valid,
    input  logic                             wr_ready,
    output logic [ADDR_W-1:0]                wr_row,
    output logic [ADDR_W-1:0]                wr_col,
    output logic [WIDTH_BIT-1:0]             wr_data,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned OUT    = out_dim(IMG_SIZE, KER_SIZE);
    localparam int unsigned TOTAL  = OUT * OUT;
    localparam int unsigned CNT_W  = $clog2(TOTAL + 1);
    localparam int unsigned STEP_W = $clog2(NCORE + 1);
    localparam int unsigned IDX_W  = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam int unsigned LAT_W  = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam int unsigned CMP_W  = (CNT_W > STEP_W) ? CNT_W : STEP_W;

    localparam logic [STEP_W-1:0] NcoreC   = STEP_W'(NCORE);
    localparam logic [LAT_W-1:0]  LatLastC = LAT_W'(CORE_LAT - 1);
    localparam logic [CNT_W-1:0]  TotalC   = CNT_W'(TOTAL);
    localparam logic [ADDR_W-1:0] OutLastC = ADDR_W'(OUT - 1);

    sched_state_t                   state_q, state_d;
    logic [STEP_W-1:0]              batch_q, batch_d;
    logic [LAT_W-1:0]               lat_q, lat_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NCORE-1:0][WIDTH_BIT-1:0] res_q, res_d;
    logic [NCORE-1:0][ADDR_W-1:0]   wrow_q, wrow_d;
    logic [NCORE-1:0][ADDR_W-1:0]   wcol_q, wcol_d;

    logic [ADDR_W-1:0]              ptr_row, ptr_col;
    logic [CNT_W-1:0]               issued;
    logic                           all_issued;
    logic [CMP_W-1:0]               remaining;
    logic [STEP_W-1:0]              batch_now;
    logic [NCORE-1:0][ADDR_W-1:0]   cand_row, cand_col;
    logic [ADDR_W-1:0]              win_r, win_c;

    window_raster_counter #(
        .OUT      (OUT),
        .ADDR_W   (ADDR_W),
        .MAX_STEP (NCORE),
        .CNT_W    (CNT_W),
        .STEP_W   (STEP_W)
    ) u_raster (
        .clock   (clock),
        .nreset  (nreset),
        .clear   (state_q == IDLE && start),
        .advance (state_q == ISSUE),
        .step_n  (batch_now),
        .row     (ptr_row),
        .col     (ptr_col),
        .count   (issued),
        .last    (all_issued)
    );

    assign remaining = CMP_W'(TotalC - issued);
    assign batch_now = (remaining >= CMP_W'(NCORE)) ? NcoreC : STEP_W'(remaining);

    // Successive raster windows starting at the pointer, one per core slot.
    always_comb begin
        win_r    = ptr_row;
        win_c    = ptr_col;
        cand_row = '0;
        cand_col = '0;
        for (int unsigned k = 0; k < NCORE; k++) begin
            cand_row[k] = win_r;
            cand_col[k] = win_c;
            if (win_c == OutLastC) begin
                win_c = '0;
                win_r = win_r + ADDR_W'(1);
            end else begin
                win_c = win_c + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        batch_d     = batch_q;
        lat_d       = lat_q;
        idx_d       = idx_q;
        res_d       = res_q;
        wrow_d      = wrow_q;
        wcol_d      = wcol_q;
        issue_valid = '0;
        issue_row   = '0;
        issue_col   = '0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                batch_d = batch_now;
                lat_d   = '0;
                state_d = WAIT;
                for (int unsigned k = 0; k < NCORE; k++) begin
                    if (STEP_W'(k) < batch_now) begin
                        issue_valid[k] = 1'b1;
                        issue_row[k]   = cand_row[k];
                        issue_col[k]   = cand_col[k];
                        wrow_d[k]      = cand_row[k];
                        wcol_d[k]      = cand_col[k];
                    end else begin
                        wrow_d[k] = '0;
                        wcol_d[k] = '0;
                    end
                end
            end
            WAIT: begin
                if (lat_q == LatLastC) begin
                    for (int unsigned k = 0; k < NCORE; k++) begin
                        res_d[k] = (STEP_W'(k) < batch_q) ? core_result[k] : '0;
                    end
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            DRAIN: begin
                if (wr_ready) begin
                    if ((STEP_W'(idx_q) + STEP_W'(1)) == batch_q) begin
                        state_d = all_issued ? FIN : ISSUE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            state_q <= IDLE;
            batch_q <= '0;
            lat_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            wrow_q  <= '0;
            wcol_q  <= '0;
        end else begin
            state_q <= state_d;
            batch_q <= batch_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
        end
    end

    assign wr_valid = (state_q == DRAIN);
    assign wr_row   = wr_valid ? wrow_q[idx_q] : '0;
    assign wr_col   = wr_valid ? wcol_q[idx_q] : '0;
    assign wr_data  = wr_valid ? relu(res_q[idx_q]) : '0;
    assign busy     = (state_q == ISSUE) || (state_q == WAIT) || (state_q == DRAIN);

endmodule
